// File: rtl/data_mem_rsp_pkg.sv
// Shared codes for the data-memory responder: access sizes,
// FSM states and small decode helpers.
package data_mem_rsp_pkg;

    localparam logic [2:0] SEL_B  = 3'b000;
    localparam logic [2:0] SEL_H  = 3'b001;
    localparam logic [2:0] SEL_W  = 3'b010;
    localparam logic [2:0] SEL_BU = 3'b100;
    localparam logic [2:0] SEL_HU = 3'b101;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_ACC  = 2'd2
    } dm_state_e;

    // Misalignment, unknown size, or unsigned size on a store.
    function automatic logic req_bad(
        input logic       we,
        input logic [2:0] sel,
        input logic [1:0] off
    );
        logic bad;
        bad = 1'b1;
        case (sel)
            SEL_B:   bad = 1'b0;
            SEL_BU:  bad = we;
            SEL_H:   bad = off[0];
            SEL_HU:  bad = we | off[0];
            SEL_W:   bad = |off;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_en(
        input logic [2:0] sel,
        input logic [1:0] off
    );
        logic [3:0] be;
        case (sel[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_mem_rsp_ld_ext.sv
// Load lane select and sign/zero extension.
module data_mem_rsp_ld_ext
    import data_mem_rsp_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  sel_type,
    output logic [31:0] value
);

    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? word[31:16] : word[15:0];
        case (sel_type)
            SEL_B:   value = {{24{b[7]}}, b};
            SEL_BU:  value = {24'd0, b};
            SEL_H:   value = {{16{h[15]}}, h};
            SEL_HU:  value = {16'd0, h};
            SEL_W:   value = word;
            default: value = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_mem_rsp.sv
// Data-memory responder: latched request, optional wait states,
// byte-lane stores and extended loads on a word RAM.
module data_mem_rsp
    import data_mem_rsp_pkg::*;
#(
    parameter int    ADDR_W    = 10,
    parameter int    WAIT_CYC  = 0,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  sel_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int AW = ADDR_W + 2;
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

    dm_state_e state, state_nx;
    logic [3:0] cnt;

    logic          r_we;
    logic [2:0]    r_sel;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;

    logic [31:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] idx;
    logic [1:0]        off;
    logic              bad;
    logic [3:0]        be;
    logic [31:0]       wsh;
    logic [31:0]       rd_word;
    logic [31:0]       ld_val;
    logic              acc;
    logic              wr_en;
    logic              unused_addr;

    // Upper address bits wrap; they never reach the RAM.
    assign unused_addr = ^addr[31:AW];

    assign idx     = r_addr[AW-1:2];
    assign off     = r_addr[1:0];
    assign bad     = req_bad(r_we, r_sel, off);
    assign be      = lane_en(r_sel, off);
    assign wsh     = r_wdata << {off, 3'b000};
    assign acc     = (state == DM_ACC);
    assign wr_en   = acc & r_we & ~bad;
    assign rd_word = mem[idx];
    assign busy    = (state != DM_IDLE);

    data_mem_rsp_ld_ext u_ld_ext (
        .word     (rd_word),
        .off      (off),
        .sel_type (r_sel),
        .value    (ld_val)
    );

    always_comb begin
        state_nx = state;
        case (state)
            DM_IDLE:
                if (req)
                    state_nx = (WAIT_CYC == 0) ? DM_ACC : DM_WAIT;
            DM_WAIT:
                if (cnt == 4'd0)
                    state_nx = DM_ACC;
            DM_ACC:
                state_nx = DM_IDLE;
            default:
                state_nx = DM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= DM_IDLE;
            cnt     <= 4'd0;
            r_we    <= 1'b0;
            r_sel   <= SEL_W;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            ack     <= 1'b0;
            err     <= 1'b0;
            rdata   <= 32'd0;
        end else begin
            state <= state_nx;
            ack   <= acc;
            if (state == DM_IDLE && req) begin
                r_we    <= we;
                r_sel   <= sel_type;
                r_addr  <= addr[AW-1:0];
                r_wdata <= wdata;
                cnt     <= CNT_INIT;
            end else if (state == DM_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (acc) begin
                err   <= bad;
                rdata <= (r_we | bad) ? 32'd0 : ld_val;
            end
        end
    end

    // RAM contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[idx][8*i +: 8] <= wsh[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_rsp.sv
// Directed bench for data_mem_rsp: one instance without wait
// states, one with three.
module tb_data_mem_rsp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req3 = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  sel_type = 3'b010;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;

    logic        busy0, ack0, err0;
    logic [31:0] rdata0;
    logic        busy3, ack3, err3;
    logic [31:0] rdata3;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    data_mem_rsp #(.ADDR_W(10), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we),
        .sel_type(sel_type), .addr(addr), .wdata(wdata),
        .busy(busy0), .ack(ack0), .rdata(rdata0), .err(err0)
    );

    data_mem_rsp #(.ADDR_W(10), .WAIT_CYC(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .we(we),
        .sel_type(sel_type), .addr(addr), .wdata(wdata),
        .busy(busy3), .ack(ack3), .rdata(rdata3), .err(err3)
    );

    // Drive one request, wait (bounded) for its ack.
    // lat = edges from sampling edge to ack, -1 on timeout.
    task automatic issue(
        input  bit          d3,
        input  logic        w,
        input  logic [2:0]  s,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        output logic [31:0] rd,
        output logic        e,
        output int          lat,
        output int          bcnt
    );
        @(negedge clk);
        we = w; sel_type = s; addr = a; wdata = wd;
        if (d3) req3 = 1'b1;
        else    req0 = 1'b1;
        @(posedge clk);
        #1;
        req0 = 1'b0; req3 = 1'b0;
        lat = -1; bcnt = 0; rd = 32'hx; e = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            bcnt += int'(d3 ? busy3 : busy0);
            @(posedge clk);
            #1;
            if (d3 ? ack3 : ack0) begin
                lat = i;
                rd  = d3 ? rdata3 : rdata0;
                e   = d3 ? err3 : err0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #12;
        total++;
        if ({busy0, ack0, err0, rdata0} !== 35'd0) begin
            bad++;
            $display("FAIL reset0: got b%b a%b e%b r%h want 0",
                     busy0, ack0, err0, rdata0);
        end
        total++;
        if ({busy3, ack3, err3, rdata3} !== 35'd0) begin
            bad++;
            $display("FAIL reset3: got b%b a%b e%b r%h want 0",
                     busy3, ack3, err3, rdata3);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word;
        logic [31:0] rd;
        logic e;
        int lat, bc;
        issue(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, rd, e, lat, bc);
        total++;
        if (lat !== 1 || e !== 1'b0 || rd !== 32'd0) begin
            bad++;
            $display("FAIL sw_word: got lat%0d e%b r%h want 1 0 0",
                     lat, e, rd);
        end
        issue(0, 0, 3'b010, 32'h10, 32'h0, rd, e, lat, bc);
        total++;
        if (lat !== 1 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL lw_word: got lat%0d e%b r%h want 1 0 deadbeef",
                     lat, e, rd);
        end
    endtask

    task automatic test_extend;
        logic [2:0]  s [5] = '{3'b000, 3'b100, 3'b001,
                               3'b101, 3'b000};
        logic [31:0] a [5] = '{32'h13, 32'h13, 32'h10,
                               32'h12, 32'h10};
        logic [31:0] x [5] = '{32'hFFFFFFDE, 32'h000000DE,
                               32'hFFFFBEEF, 32'h0000DEAD,
                               32'hFFFFFFEF};
        logic [31:0] rd;
        logic e;
        int lat, bc;
        for (int i = 0; i < 5; i++) begin
            issue(0, 0, s[i], a[i], 32'h0, rd, e, lat, bc);
            total++;
            if (rd !== x[i] || e !== 1'b0) begin
                bad++;
                $display("FAIL load_ext%0d: got r%h e%b want %h 0",
                         i, rd, e, x[i]);
            end
        end
    endtask

    task automatic test_lanes;
        logic [31:0] rd;
        logic e;
        int lat, bc;
        issue(0, 1, 3'b000, 32'h11, 32'hAAAAAA55, rd, e, lat, bc);
        issue(0, 0, 3'b010, 32'h10, 32'h0, rd, e, lat, bc);
        total++;
        if (rd !== 32'hDEAD55EF) begin
            bad++;
            $display("FAIL sb_lane: got %h want dead55ef", rd);
        end
        issue(0, 1, 3'b001, 32'h12, 32'hFFFF1234, rd, e, lat, bc);
        total++;
        if (rd !== 32'd0 || e !== 1'b0) begin
            bad++;
            $display("FAIL store_rdata: got r%h e%b want 0 0", rd, e);
        end
        issue(0, 0, 3'b010, 32'h10, 32'h0, rd, e, lat, bc);
        total++;
        if (rd !== 32'h123455EF) begin
            bad++;
            $display("FAIL sh_lane: got %h want 123455ef", rd);
        end
        issue(0, 0, 3'b100, 32'h11, 32'h0, rd, e, lat, bc);
        total++;
        if (rd !== 32'h00000055) begin
            bad++;
            $display("FAIL lbu_mid: got %h want 00000055", rd);
        end
        issue(0, 0, 3'b010, 32'h1010, 32'h0, rd, e, lat, bc);
        total++;
        if (rd !== 32'h123455EF) begin
            bad++;
            $display("FAIL addr_wrap: got %h want 123455ef", rd);
        end
    endtask

    task automatic test_errors;
        logic        w [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  s [5] = '{3'b010, 3'b001, 3'b011,
                               3'b100, 3'b001};
        logic [31:0] a [5] = '{32'h11, 32'h13, 32'h10,
                               32'h10, 32'h11};
        logic [31:0] rd;
        logic e;
        int lat, bc;
        for (int i = 0; i < 5; i++) begin
            issue(0, w[i], s[i], a[i], 32'h0, rd, e, lat, bc);
            total++;
            if (e !== 1'b1 || rd !== 32'd0 || lat !== 1) begin
                bad++;
                $display("FAIL err%0d: got e%b r%h lat%0d want 1 0 1",
                         i, e, rd, lat);
            end
        end
        issue(0, 0, 3'b010, 32'h10, 32'h0, rd, e, lat, bc);
        total++;
        if (rd !== 32'h123455EF || e !== 1'b0) begin
            bad++;
            $display("FAIL err_no_write: got r%h e%b want 123455ef 0",
                     rd, e);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        logic e;
        int lat, bc;
        issue(0, 1, 3'b010, 32'h30, 32'hCAFEF00D, rd, e, lat, bc);
        issue(0, 0, 3'b010, 32'h30, 32'h0, rd, e, lat, bc);
        total++;
        if (rd !== 32'hCAFEF00D || lat !== 1) begin
            bad++;
            $display("FAIL raw_b2b: got r%h lat%0d want cafef00d 1",
                     rd, lat);
        end
    endtask

    task automatic test_wait;
        logic [31:0] rd;
        logic e;
        int lat, bc;
        issue(1, 1, 3'b010, 32'h20, 32'hA5A5A5A5, rd, e, lat, bc);
        total++;
        if (lat !== 4 || bc !== 4 || e !== 1'b0) begin
            bad++;
            $display("FAIL wait_lat: got lat%0d busy%0d e%b want 4 4 0",
                     lat, bc, e);
        end
        total++;
        if (busy3 !== 1'b0) begin
            bad++;
            $display("FAIL wait_busy_ack: got %b want 0", busy3);
        end
        @(posedge clk);
        #1;
        total++;
        if (ack3 !== 1'b0) begin
            bad++;
            $display("FAIL ack_pulse: got %b want 0", ack3);
        end
    endtask

    task automatic test_busy_ignore;
        logic [31:0] rd;
        logic e;
        int lat, bc;
        int acks;
        logic [31:0] first;
        acks = 0;
        first = 32'hx;
        @(negedge clk);
        we = 0; sel_type = 3'b010; addr = 32'h20; req3 = 1'b1;
        @(posedge clk);
        #1;
        req3 = 1'b0;
        @(negedge clk);
        we = 1; wdata = 32'h0; req3 = 1'b1;
        @(posedge clk);
        #1;
        req3 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (ack3) begin
                if (acks == 0) first = rdata3;
                acks++;
            end
        end
        total++;
        if (acks !== 1 || first !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL busy_ignore: got acks%0d r%h want 1 a5a5a5a5",
                     acks, first);
        end
        issue(1, 0, 3'b010, 32'h20, 32'h0, rd, e, lat, bc);
        total++;
        if (rd !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL busy_no_write: got %h want a5a5a5a5", rd);
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] rd;
        logic e;
        int lat, bc;
        int acks;
        acks = 0;
        @(negedge clk);
        we = 1; sel_type = 3'b010; addr = 32'h20;
        wdata = 32'h11111111; req3 = 1'b1;
        @(posedge clk);
        #1;
        req3 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({busy3, ack3, err3, rdata3} !== 35'd0) begin
            bad++;
            $display("FAIL abort_outs: got b%b a%b e%b r%h want 0",
                     busy3, ack3, err3, rdata3);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (ack3) acks++;
        end
        total++;
        if (acks !== 0) begin
            bad++;
            $display("FAIL abort_ack: got %0d acks want 0", acks);
        end
        issue(1, 0, 3'b010, 32'h20, 32'h0, rd, e, lat, bc);
        total++;
        if (rd !== 32'hA5A5A5A5 || lat !== 4) begin
            bad++;
            $display("FAIL abort_mem: got r%h lat%0d want a5a5a5a5 4",
                     rd, lat);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_extend();
        test_lanes();
        test_errors();
        test_back_to_back();
        test_wait();
        test_busy_ignore();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
